complex_mult_host_if: RTL

- Host-side companion to the complex number multiplier. It sits at the other end of the multiplier's op_val/op_ready and res_val/res_ready handshakes.
- The host pushes operand pairs into an operand FIFO. The block issues them to the multiplier, collects returned results into a result FIFO in order, and presents them to the host.
- Credit-based issue: an operand is issued only when a result slot is guaranteed, so a returned result is never dropped.

---
 rtl/complex_mult_host_if.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/complex_mult_host_if.sv
// Host-side companion to the complex multiplier. It buffers host operand
// pairs, issues them to the multiplier against a result-slot credit, and
// returns results to the host in issue order.
module complex_mult_host_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    sw_rst,
    // host operand side
    input  logic                    in_val,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_1_re,
    input  logic [DATA_WIDTH-1:0]   in_1_im,
    input  logic [DATA_WIDTH-1:0]   in_2_re,
    input  logic [DATA_WIDTH-1:0]   in_2_im,
    // multiplier operand side
    output logic                    op_val,
    input  logic                    op_ready,
    output logic [DATA_WIDTH-1:0]   op_1_re,
    output logic [DATA_WIDTH-1:0]   op_1_im,
    output logic [DATA_WIDTH-1:0]   op_2_re,
    output logic [DATA_WIDTH-1:0]   op_2_im,
    // multiplier result side
    input  logic                    res_val,
    output logic                    res_ready,
    input  logic [2*DATA_WIDTH-1:0] mult_re,
    input  logic [2*DATA_WIDTH-1:0] mult_im,
    // host result side
    output logic                    out_val,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_re,
    output logic [2*DATA_WIDTH-1:0] out_im,
    // status
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic                    proto_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned RES_W = 2 * DATA_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a_re;
        logic [DATA_WIDTH-1:0] a_im;
        logic [DATA_WIDTH-1:0] b_re;
        logic [DATA_WIDTH-1:0] b_im;
    } op_pair_t;

    typedef struct packed {
        logic [RES_W-1:0] re;
        logic [RES_W-1:0] im;
    } res_pair_t;

    op_pair_t         op_mem_q [DEPTH];
    op_pair_t         op_mem_d [DEPTH];
    logic [PTR_W-1:0] op_wr_ptr_q, op_wr_ptr_d;
    logic [PTR_W-1:0] op_rd_ptr_q, op_rd_ptr_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;

    res_pair_t        res_mem_q [DEPTH];
    res_pair_t        res_mem_d [DEPTH];
    logic [PTR_W-1:0] res_wr_ptr_q, res_wr_ptr_d;
    logic [PTR_W-1:0] res_rd_ptr_q, res_rd_ptr_d;
    logic [CNT_W-1:0] res_count_q,  res_count_d;

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             proto_err_q,   proto_err_d;

    op_pair_t         op_head;
    res_pair_t        res_head;
    logic             credit_ok;
    logic             in_fire;
    logic             issue_fire;
    logic             ret_take;
    logic             ret_fire;
    logic             ret_err;
    logic             out_fire;

    // Handshake qualifiers; all derive from registered state plus the inputs.
    always_comb begin
        op_head    = op_mem_q[op_rd_ptr_q];
        res_head   = res_mem_q[res_rd_ptr_q];
        // an issue is allowed only if every in-flight result still has a slot
        credit_ok  = (SUM_W'(res_count_q) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH);
        in_ready   = op_count_q < CNT_W'(DEPTH);
        op_val     = (op_count_q != '0) && credit_ok;
        res_ready  = res_count_q < CNT_W'(DEPTH);
        out_val    = res_count_q != '0;
        in_fire    = in_val && in_ready;
        issue_fire = op_val && op_ready;
        ret_take   = res_val && res_ready;
        ret_fire   = ret_take && (outstanding_q != '0);
        ret_err    = ret_take && (outstanding_q == '0);
        out_fire   = out_val && out_ready;
    end

    // Data outputs are forced to zero whenever their valid is low.
    always_comb begin
        op_1_re     = op_val  ? op_head.a_re : '0;
        op_1_im     = op_val  ? op_head.a_im : '0;
        op_2_re     = op_val  ? op_head.b_re : '0;
        op_2_im     = op_val  ? op_head.b_im : '0;
        out_re      = out_val ? res_head.re  : '0;
        out_im      = out_val ? res_head.im  : '0;
        outstanding = outstanding_q;
        proto_err   = proto_err_q;
    end

    // Operand FIFO next state.
    always_comb begin
        op_mem_d    = op_mem_q;
        op_wr_ptr_d = op_wr_ptr_q;
        op_rd_ptr_d = op_rd_ptr_q;
        op_count_d  = op_count_q;
        if (in_fire) begin
            op_mem_d[op_wr_ptr_q] = '{a_re: in_1_re, a_im: in_1_im,
                                      b_re: in_2_re, b_im: in_2_im};
            op_wr_ptr_d = op_wr_ptr_q + PTR_W'(1);
        end
        if (issue_fire) begin
            op_rd_ptr_d = op_rd_ptr_q + PTR_W'(1);
        end
        case ({in_fire, issue_fire})
            2'b10:   op_count_d = op_count_q + CNT_W'(1);
            2'b01:   op_count_d = op_count_q - CNT_W'(1);
            default: op_count_d = op_count_q;
        endcase
    end

    // Result FIFO, credit counter and sticky error next state.
    always_comb begin
        res_mem_d     = res_mem_q;
        res_wr_ptr_d  = res_wr_ptr_q;
        res_rd_ptr_d  = res_rd_ptr_q;
        res_count_d   = res_count_q;
        outstanding_d = outstanding_q;
        proto_err_d   = proto_err_q | ret_err;
        if (ret_fire) begin
            res_mem_d[res_wr_ptr_q] = '{re: mult_re, im: mult_im};
            res_wr_ptr_d = res_wr_ptr_q + PTR_W'(1);
        end
        if (out_fire) begin
            res_rd_ptr_d = res_rd_ptr_q + PTR_W'(1);
        end
        case ({ret_fire, out_fire})
            2'b10:   res_count_d = res_count_q + CNT_W'(1);
            2'b01:   res_count_d = res_count_q - CNT_W'(1);
            default: res_count_d = res_count_q;
        endcase
        case ({issue_fire, ret_fire})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Control state with synchronous reset; reset drops all queued and in-flight work.
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            op_wr_ptr_q   <= '0;
            op_rd_ptr_q   <= '0;
            op_count_q    <= '0;
            res_wr_ptr_q  <= '0;
            res_rd_ptr_q  <= '0;
            res_count_q   <= '0;
            outstanding_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            op_wr_ptr_q   <= op_wr_ptr_d;
            op_rd_ptr_q   <= op_rd_ptr_d;
            op_count_q    <= op_count_d;
            res_wr_ptr_q  <= res_wr_ptr_d;
            res_rd_ptr_q  <= res_rd_ptr_d;
            res_count_q   <= res_count_d;
            outstanding_q <= outstanding_d;
            proto_err_q   <= proto_err_d;
        end
    end

    // FIFO storage; contents are never visible unless the matching count is non-zero.
    always_ff @(posedge clk) begin
        op_mem_q  <= op_mem_d;
        res_mem_q <= res_mem_d;
    end

endmodule
